// File: rtl/mix_unmixer.sv
// mix_unmixer: iterative inverse of the 8-lane add/xor-shift mixing round.
// A mixed 8-word frame is loaded lane 0 first. It is unmixed in place one lane
// operation per clock: an xor-undo sweep from lane 7 down to lane 0, then a
// subtract-undo sweep from lane 7 down to lane 0. The two sweeps repeat once
// per round. The recovered frame is then streamed out lane 0 first, with
// m_last marking the lane-7 beat.
module mix_unmixer #(
    parameter int W      = 32,
    parameter int SHIFT  = 16,
    parameter int ROUNDS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_XOR   = 2'd1,
        ST_SUB   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // The round counter needs at least one bit, even when ROUNDS is 1.
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [RW-1:0] round_q, round_d;

    // Lane storage. Three lanes are read at once (the current lane plus two
    // neighbours), so the lanes are plain registers rather than a RAM.
    logic [W-1:0]  o_q [8];
    logic [W-1:0]  o_d [8];

    logic          lane_we;
    logic [W-1:0]  lane_wdata;
    logic [7:0]    lane_sel;

    // Neighbour indices wrap naturally mod 8 in 3-bit arithmetic.
    logic [2:0]    idx_xor_nbr;
    logic [2:0]    idx_sub_nbr;
    logic [W-1:0]  cur_lane;
    logic [W-1:0]  xor_nbr_lane;
    logic [W-1:0]  sub_nbr_lane;

    assign idx_xor_nbr  = idx_q + 3'd3;
    assign idx_sub_nbr  = idx_q - 3'd1;
    assign cur_lane     = o_q[idx_q];
    assign xor_nbr_lane = o_q[idx_xor_nbr];
    assign sub_nbr_lane = o_q[idx_sub_nbr];

    // Next-state, index, round and lane-write decode for the load/compute/drain sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        round_d    = round_q;
        lane_we    = 1'b0;
        lane_wdata = s_data;
        case (state_q)
            ST_LOAD: begin
                if (s_valid) begin
                    lane_we    = 1'b1;
                    lane_wdata = s_data;
                    if (idx_q == 3'd7) begin
                        state_d = ST_XOR;
                        idx_d   = 3'd7;
                        round_d = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_XOR: begin
                // Walking down from lane 7, lane idx+3 still holds the value
                // the forward pass xored in, so a single xor restores it.
                lane_we    = 1'b1;
                lane_wdata = cur_lane ^ (xor_nbr_lane << SHIFT);
                idx_d      = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    state_d = ST_SUB;
                    idx_d   = 3'd7;
                end
            end
            ST_SUB: begin
                // For the same reason, lane idx-1 still holds the value that
                // the forward add pass added in.
                lane_we    = 1'b1;
                lane_wdata = cur_lane - sub_nbr_lane;
                idx_d      = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_DRAIN;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_XOR;
                        idx_d   = 3'd7;
                        round_d = round_q + RW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_LOAD;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = 3'd0;
                round_d = '0;
            end
        endcase
    end

    // Decode a one-hot write strobe for each lane.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane_sel
        assign lane_sel[gi] = lane_we && (idx_q == 3'(gi));
    end

    // Next value of every lane: only the selected lane takes the write data.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            o_d[i] = lane_sel[i] ? lane_wdata : o_q[i];
        end
    end

    // Sequencer registers: state, lane index and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= 3'd0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
        end
    end

    // Lane registers. Reset clears them so no stale lanes survive an aborted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                o_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                o_q[i] <= o_d[i];
            end
        end
    end

    // All outputs are decoded from registered state only.
    assign s_ready = (state_q == ST_LOAD);
    assign m_valid = (state_q == ST_DRAIN);
    assign m_data  = m_valid ? cur_lane : '0;
    assign m_last  = m_valid && (idx_q == 3'd7);
    assign busy    = (state_q != ST_LOAD);

endmodule

// File: tb/tb_mix_unmixer.sv
// Testbench for mix_unmixer. Three instances are built, with ROUNDS = 1, 3 and 2.
// A frame-level forward/inverse model supplies the expected words. A single
// compare process checks every instance on each falling edge.
module tb_mix_unmixer;

    typedef logic [31:0] frame_t [8];

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid [3];
    logic        s_ready [3];
    logic [31:0] s_data  [3];
    logic        m_valid [3];
    logic        m_ready [3];
    logic [31:0] m_data  [3];
    logic        m_last  [3];
    logic        busy    [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected-word FIFOs, one per instance.
    logic [31:0] exp_mem [3][1024];
    int head [3] = '{default: 0};
    int tail [3] = '{default: 0};

    // Bench-side frame tracking used by the compare process.
    int in_cnt    [3] = '{default: 0};
    int out_idx   [3] = '{default: 0};
    int last_acc  [3] = '{default: 0};
    bit in_flight [3] = '{default: 0};
    bit prev_mv   [3] = '{default: 0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mix_unmixer #(
            .W(32),
            .SHIFT(16),
            .ROUNDS(gi == 0 ? 1 : (gi == 1 ? 3 : 2))
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .s_valid(s_valid[gi]),
            .s_ready(s_ready[gi]),
            .s_data (s_data[gi]),
            .m_valid(m_valid[gi]),
            .m_ready(m_ready[gi]),
            .m_data (m_data[gi]),
            .m_last (m_last[gi]),
            .busy   (busy[gi])
        );
    end

    function automatic int rounds_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Forward mixing round, applied rounds times, as described for the mixer.
    task automatic fwd_model(input frame_t in, input int rounds, output frame_t out);
        out = in;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 8; i++) out[i] = out[i] + out[(i + 7) % 8];
            for (int i = 0; i < 8; i++) out[i] = out[i] ^ (out[(i + 3) % 8] << 16);
        end
    endtask

    // Inverse round, applied rounds times.
    task automatic inv_model(input frame_t in, input int rounds, output frame_t out);
        out = in;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 7; i >= 0; i--) out[i] = out[i] ^ (out[(i + 3) % 8] << 16);
            for (int i = 7; i >= 0; i--) out[i] = out[i] - out[(i + 7) % 8];
        end
    endtask

    task automatic push_frame(input int k, input frame_t f);
        for (int i = 0; i < 8; i++) begin
            exp_mem[k][tail[k] % 1024] = f[i];
            tail[k]++;
        end
    endtask

    // Hold one beat until it is accepted. Call 1 ns after a rising edge.
    task automatic wait_acc(input int k);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            got = s_ready[k];
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut%0d actual=no_accept required=accept", k);
        end
    endtask

    task automatic send_frame(input int k, input frame_t f);
        for (int i = 0; i < 8; i++) begin
            s_valid[k] = 1'b1;
            s_data[k]  = f[i];
            wait_acc(k);
        end
        s_valid[k] = 1'b0;
        s_data[k]  = '0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((head[k] != tail[k] || busy[k]) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (head[k] != tail[k] || busy[k]) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout dut%0d actual=pending=%0d required=pending=0", k, tail[k] - head[k]);
        end
    endtask

    task automatic check_reset(input int k);
        chk($sformatf("rst_s_ready[%0d]", k), s_ready[k], 1);
        chk($sformatf("rst_m_valid[%0d]", k), m_valid[k], 0);
        chk($sformatf("rst_m_last[%0d]", k), m_last[k], 0);
        chk($sformatf("rst_m_data[%0d]", k), m_data[k], 0);
        chk($sformatf("rst_busy[%0d]", k), busy[k], 0);
    endtask

    // Compare process: handshake rules, busy, latency and output data, every cycle.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                head[k]      = tail[k];
                in_cnt[k]    = 0;
                out_idx[k]   = 0;
                in_flight[k] = 1'b0;
                prev_mv[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("s_ready_vs_busy[%0d]", k), s_ready[k], !busy[k]);
                chk($sformatf("busy[%0d]", k), busy[k], in_flight[k]);
                chk($sformatf("no_overlap[%0d]", k), s_ready[k] && m_valid[k], 0);
                if (m_valid[k]) begin
                    if (!prev_mv[k])
                        chk($sformatf("latency[%0d]", k), 32'(cyc - last_acc[k]), 32'(1 + 16 * rounds_of(k)));
                    if (head[k] == tail[k]) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat[%0d] actual=%h required=no_beat", k, m_data[k]);
                    end else begin
                        chk($sformatf("m_data[%0d] beat%0d", k, out_idx[k]), m_data[k], exp_mem[k][head[k] % 1024]);
                        chk($sformatf("m_last[%0d] beat%0d", k, out_idx[k]), m_last[k], out_idx[k] == 7);
                        if (m_ready[k]) begin
                            head[k]++;
                            if (out_idx[k] == 7) begin
                                out_idx[k]   = 0;
                                in_flight[k] = 1'b0;
                            end else begin
                                out_idx[k]++;
                            end
                        end
                    end
                end
                if (s_valid[k] && s_ready[k]) begin
                    in_cnt[k]++;
                    if (in_cnt[k] == 8) begin
                        in_cnt[k]    = 0;
                        in_flight[k] = 1'b1;
                        last_acc[k]  = cyc;
                    end
                end
                prev_mv[k] = m_valid[k];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t vec, vec2, seed, fr, mdl, zero;
        vec  = '{32'h000D0007, 32'h00110008, 32'h0016000A, 32'h001C000D,
                 32'h00230011, 32'h00070016, 32'h0008001C, 32'h000A0023};
        vec2 = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF,
                 32'h00000001, 32'h80000000, 32'h55AA55AA, 32'h0F0F0F0F};
        for (int i = 0; i < 8; i++) begin
            seed[i] = 32'(i);
            zero[i] = '0;
        end

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = '0;
            m_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset(k);

        // Hand-computed values that pin the model.
        fwd_model(seed, 1, mdl);
        for (int i = 0; i < 8; i++) chk($sformatf("model_fwd lane%0d", i), mdl[i], vec[i]);
        inv_model(vec, 1, mdl);
        for (int i = 0; i < 8; i++) chk($sformatf("model_inv lane%0d", i), mdl[i], 32'(i));
        inv_model(zero, 3, mdl);
        for (int i = 0; i < 8; i++) chk($sformatf("model_zero lane%0d", i), mdl[i], 32'h0);

        @(posedge clk);
        #1;

        // Reference frame, with m_ready dropped for 5 cycles while beat 3 is shown.
        inv_model(vec, 1, mdl);
        push_frame(0, mdl);
        send_frame(0, vec);
        repeat (19) @(posedge clk);
        #1 m_ready[0] = 1'b0;
        @(negedge clk);
        chk("stall_m_valid", m_valid[0], 1);
        chk("stall_m_data", m_data[0], 32'h3);
        repeat (5) @(posedge clk);
        #1 m_ready[0] = 1'b1;
        wait_idle(0);

        // Back-to-back frames: the next frame's first beat is offered during compute.
        inv_model(vec, 1, mdl);
        push_frame(0, mdl);
        send_frame(0, vec);
        inv_model(vec2, 1, mdl);
        push_frame(0, mdl);
        send_frame(0, vec2);
        wait_idle(0);

        // Reset in the middle of the xor sweep, then a clean reference frame.
        inv_model(vec2, 1, mdl);
        push_frame(0, mdl);
        send_frame(0, vec2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset(0);
        @(posedge clk);
        #1;
        inv_model(vec, 1, mdl);
        push_frame(0, mdl);
        send_frame(0, vec);
        wait_idle(0);

        // All-zero frame through three rounds.
        inv_model(zero, 3, mdl);
        push_frame(1, mdl);
        send_frame(1, zero);
        wait_idle(1);

        // Random seeds, mixed by the forward model over two rounds, must come back unchanged.
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 8; i++) seed[i] = $urandom;
            fwd_model(seed, 2, fr);
            push_frame(2, seed);
            send_frame(2, fr);
        end
        wait_idle(2);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_unmixer.md
Name: mix_unmixer

Overview:
- Iterative inverse of the 8-lane add/xor-shift mixing round used by the team's multi-lane mixers. Given a mixed state, it recovers the pre-mix state.
- Used as the decode/checker end: the mixer output is streamed in, unmixed, and streamed back out for comparison against the seed.
- Processes one lane operation per cycle to keep the area small.
- Input is an 8-beat valid/ready stream; output is an 8-beat valid/ready stream with a last flag.

Parameters:
- W, 32: lane width in bits.
- SHIFT, 16: left-shift amount in the xor pass, 0 < SHIFT < W.
- ROUNDS, 1: number of inverse rounds, ≥ 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block accepts input word.
- s_data  in  W  mixed lane word; beats are lane 0 first, lane 7 last.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts output word.
- m_data  out  W  unmixed lane word; lane 0 first.
- m_last  out  1  high on the lane-7 output beat.
- busy  out  1  high in any state other than LOAD.

Behaviour:
- Forward round being inverted (lanes o[0..7], indices mod 8, all arithmetic mod 2^W, updates sequential and in place):
  - Add pass: for i = 0..7, o[i] += o[i-1].
  - Xor pass: for i = 0..7, o[i] ^= (o[i+3] << SHIFT), truncated to W bits.
- Inverse round:
  - Xor-undo: for i = 7 down to 0, o[i] ^= (o[i+3] << SHIFT).
  - Then sub-undo: for i = 7 down to 0, o[i] -= o[i-1].
  - Each lane operation takes exactly one clock.
- State machine: LOAD → XOR → SUB → (XOR if rounds remain, else DRAIN) → LOAD.
- LOAD:
  - s_ready = 1, m_valid = 0.
  - Each accepted beat (s_valid & s_ready) writes o[idx]; idx counts 0→7.
  - Acceptance of lane 7 → XOR, with idx = 7 and round = 0.
- XOR:
  - s_ready = 0; one xor-undo on lane idx per cycle; idx decrements.
  - After idx = 0 → SUB, with idx = 7.
- SUB:
  - One subtract on lane idx per cycle; idx decrements.
  - After idx = 0: if round == ROUNDS-1 → DRAIN with idx = 0; else round++ → XOR with idx = 7.
- DRAIN:
  - m_valid = 1, m_data = o[idx], m_last = (idx == 7).
  - On m_valid & m_ready, idx increments.
  - Acceptance of lane 7 → LOAD with idx = 0.
  - m_valid holds and m_data stays stable while m_ready = 0.
- Latency: the last input beat accepted in cycle t gives the first m_valid in cycle t + 1 + 16·ROUNDS. With no backpressure, the drain takes 8 cycles.
- Input offered while busy is not accepted (s_ready = 0) and has no effect.
- s_ready is never high in the same cycle as m_valid, so there is no overlap between loading and draining.
- Reset, including mid-LOAD, mid-compute or mid-DRAIN:
  - state = LOAD, idx = 0, round = 0, all o[] = 0.
  - s_ready = 1, m_valid = 0, m_last = 0, m_data = 0, busy = 0.
  - A partial frame is discarded.
- Outputs are registered or decoded from registered state only; there is no combinational path from s_* to m_*.

Test Plan:
- ROUNDS=1: feed {0x000D0007, 0x00110008, 0x0016000A, 0x001C000D, 0x00230011, 0x00070016, 0x0008001C, 0x000A0023} → output 0,1,2,3,4,5,6,7, m_last on the 8th beat, first m_valid exactly 17 cycles after the last input beat.
- All-zero frame, ROUNDS=3 → eight zero output words; first m_valid 49 cycles after the last input beat; busy high throughout compute and drain.
- Output backpressure: during drain of the first test, drop m_ready for 5 cycles at beat 3 → m_data holds at 3, m_valid stays high, no beat is lost or duplicated.
- s_valid held high during compute → s_ready stays 0 and the result is unchanged; the next frame is accepted only after m_last is accepted.
- Assert rst for 1 cycle mid-XOR, then feed the first test's frame → clean restart with outputs 0..7; no stale words from the aborted frame.
- Randomised check against the forward model: 100 random seeds with ROUNDS=2, W=32, SHIFT=16 → unmixer output equals the seed for every frame.
